// File: rtl/twos_to_signmag_serial.sv
// Bit-serial 8-bit two's complement to sign-magnitude converter with valid/ready on both sides.
// Optional macro SM2TC_EN adds a MODE input for the reverse (sign-magnitude to two's complement) direction.
module twos_to_signmag_serial #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
`ifdef SM2TC_EN
  input  logic             MODE,
`endif
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic             r_seen;
  logic             r_mode;
  logic [WIDTH-1:0] r_out_data;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic             w_mode;
  logic             w_bit;
  logic             w_res_bit;

`ifdef SM2TC_EN
  assign w_mode = MODE;
`else
  assign w_mode = 1'b0;
`endif

  // Copy bits up to and including the first one, invert every bit after it.
  always_comb begin
    w_bit     = r_shift[0];
    w_res_bit = r_sign ? (w_bit ^ r_seen) : w_bit;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_seen      <= 1'b0;
      r_mode      <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IN_VALID && r_in_ready) begin
            r_shift    <= w_mode ? {1'b0, IN_DATA[WIDTH-2:0]} : IN_DATA;
            r_sign     <= IN_DATA[WIDTH-1];
            r_mode     <= w_mode;
            r_seen     <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_res   <= {w_res_bit, r_res[WIDTH-1:1]};
          r_shift <= {1'b0, r_shift[WIDTH-1:1]};
          r_seen  <= r_seen | w_bit;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the completed result; later cycles wait for the drain.
          if (!r_out_valid) begin
            r_out_data  <= r_mode ? r_res : {r_sign, r_res[WIDTH-2:0]};
            r_ovf       <= ~r_mode & r_sign & r_res[WIDTH-1];
            r_out_valid <= 1'b1;
          end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_DATA  = r_out_data;
  assign OUT_OVF   = r_ovf;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Self-checking bench for twos_to_signmag_serial: directed corner values plus random operands
// checked against an arithmetic reference model (MODE tests only when SM2TC_EN is defined).
module tb_twos_to_signmag_serial;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_OVF;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;
`ifdef SM2TC_EN
  logic       MODE;
`endif

  int checks = 0;
  int errors = 0;

  twos_to_signmag_serial #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
`ifdef SM2TC_EN
    .MODE      (MODE),
`endif
    .OUT_DATA  (OUT_DATA),
    .OUT_OVF   (OUT_OVF),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: returns {ovf, sign-magnitude} from the signed integer value.
  function automatic logic [8:0] model_tc2sm(input logic [7:0] x);
    int v;
    int m;
    v = x[7] ? int'(x) - 256 : int'(x);
    if (v >= 0) return {1'b0, x};
    m = -v;
    if (m > 127) return {1'b1, 8'h80};
    return {1'b0, 1'b1, 7'(m)};
  endfunction

  function automatic logic [7:0] model_sm2tc(input logic [7:0] x);
    int m;
    m = int'(x[6:0]);
    if (x[7]) m = -m;
    return 8'(m);
  endfunction

  // Drives one operand and waits for OUT_VALID; optionally drains with OUT_READY=1.
  task automatic run_op(input logic [7:0] d, input bit drain,
                        output logic [7:0] od, output logic ovf,
                        output int lat, output int busy_n, output bit timeout);
    int n;
    n = 0;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    IN_DATA  = d;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_DATA  = 8'($urandom);
    lat    = 0;
    busy_n = BUSY ? 1 : 0;
    while (!OUT_VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      busy_n += BUSY ? 1 : 0;
    end
    timeout = !OUT_VALID;
    od  = OUT_DATA;
    ovf = OUT_OVF;
    if (drain && !timeout) begin
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RESET_N   = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    OUT_READY = 1'b1;
`ifdef SM2TC_EN
    MODE      = 1'b0;
`endif
    #23;
    checks++;
    if ({IN_READY, OUT_VALID, OUT_DATA, OUT_OVF, BUSY} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h ovf=%b busy=%b, want 1 0 00 0 0",
               IN_READY, OUT_VALID, OUT_DATA, OUT_OVF, BUSY);
    end
    RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    logic [7:0] vals [6] = '{8'h2D, 8'hFD, 8'hD0, 8'h80, 8'h00, 8'h7F};
    logic [7:0] od;
    logic       ovf;
    logic [8:0] exp;
    int lat, bn;
    bit to;
    foreach (vals[i]) begin
      run_op(vals[i], 1'b1, od, ovf, lat, bn, to);
      exp = model_tc2sm(vals[i]);
      checks++;
      if (to || {ovf, od} !== exp) begin
        errors++;
        $display("FAIL directed_%h: got data=%h ovf=%b timeout=%0d, want data=%h ovf=%b",
                 vals[i], od, ovf, to, exp[7:0], exp[8]);
      end
      checks++;
      if (lat != 9 || bn != 8) begin
        errors++;
        $display("FAIL timing_%h: got latency=%0d busy=%0d, want 9 and 8", vals[i], lat, bn);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, od;
    logic       ovf;
    logic [8:0] exp;
    int lat, bn;
    bit to;
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      run_op(d, 1'b1, od, ovf, lat, bn, to);
      exp = model_tc2sm(d);
      checks++;
      if (to || {ovf, od} !== exp || lat != 9) begin
        errors++;
        $display("FAIL random_%h: got data=%h ovf=%b lat=%0d, want data=%h ovf=%b lat=9",
                 d, od, ovf, lat, exp[7:0], exp[8]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] od;
    logic       ovf;
    logic [8:0] exp;
    int lat, bn;
    bit to, held;
    OUT_READY = 1'b0;
    run_op(8'hEC, 1'b0, od, ovf, lat, bn, to);
    checks++;
    if (to || od !== 8'h94 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: got data=%h ovf=%b timeout=%0d, want 94 0", od, ovf, to);
    end
    held = 1'b1;
    for (int c = 0; c < 5; c++) begin
      IN_VALID = c[0];
      IN_DATA  = 8'($urandom);
      @(posedge CLK); #1;
      if (!OUT_VALID || OUT_DATA !== 8'h94 || OUT_OVF !== 1'b0 || IN_READY !== 1'b0) held = 1'b0;
    end
    IN_VALID = 1'b0;
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL bp_hold: got vld=%b data=%h rdy=%b, want 1 94 0", OUT_VALID, OUT_DATA, IN_READY);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got vld=%b rdy=%b, want 0 1", OUT_VALID, IN_READY);
    end
    run_op(8'hFD, 1'b1, od, ovf, lat, bn, to);
    exp = model_tc2sm(8'hFD);
    checks++;
    if (to || {ovf, od} !== exp || lat != 9) begin
      errors++;
      $display("FAIL back_to_back: got data=%h lat=%0d, want %h lat=9", od, lat, exp[7:0]);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit quiet;
    IN_DATA  = 8'hFD;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({IN_READY, OUT_VALID, OUT_DATA, OUT_OVF, BUSY} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_shift: got rdy=%b vld=%b data=%h ovf=%b busy=%b, want 1 0 00 0 0",
               IN_READY, OUT_VALID, OUT_DATA, OUT_OVF, BUSY);
    end
    #10;
    RESET_N = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (OUT_VALID || BUSY || !IN_READY) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_no_valid: got vld=%b busy=%b rdy=%b, want 0 0 1", OUT_VALID, BUSY, IN_READY);
    end
  endtask

`ifdef SM2TC_EN
  task automatic test_sm2tc();
    logic [7:0] vals [4] = '{8'h83, 8'hB0, 8'h80, 8'h2D};
    logic [7:0] od, exp;
    logic       ovf;
    int lat, bn;
    bit to;
    MODE = 1'b1;
    foreach (vals[i]) begin
      run_op(vals[i], 1'b1, od, ovf, lat, bn, to);
      exp = model_sm2tc(vals[i]);
      checks++;
      if (to || od !== exp || ovf !== 1'b0 || lat != 9) begin
        errors++;
        $display("FAIL sm2tc_%h: got data=%h ovf=%b lat=%0d, want %h 0 9", vals[i], od, ovf, lat, exp);
      end
    end
    MODE = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
`ifdef SM2TC_EN
    test_sm2tc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
